// File: rtl/ct_had_ddu_ctrl.sv
// ct_had_ddu_ctrl: direct-data-upload controller of the HAD debug unit.
// After the debugger writes a start address through DADDR, the block injects
// "address into r0" and "ldw r1,(r0)", captures the load writeback into DDATA
// for the debugger to shift out, and auto-increments the address on each
// DDATA capture so memory streams out without per-word address writes.
//
// Optional feature macro: HAD_DDU_UNDERRUN_EN (sticky underrun detection).
// Without it ddu_underrun is tied low.
//
// Ports:
//   cpuclk, cpurst              core clock, async active-high reset
//   regs_xx_ddu_en              upload mode enable
//   x_sm_xx_update_dr_en        TAP Update-DR strobe
//   x_sm_xx_capture_dr_en       TAP Capture-DR strobe
//   ir_xx_daddr_reg_sel         IR selects DADDR
//   ir_xx_ddata_reg_sel         IR selects DDATA
//   jtag_xx_dr_data             shifted DR value
//   rtu_yy_xx_retire0_normal    injected instruction retired
//   rtu_had_wb_data_vld/_data   load writeback
//   ddu_ctrl_dp_addr_sel        inject address instruction
//   ddu_ctrl_dp_ldw_sel         inject load-word instruction
//   ddu_xx_update_ir            load injected instruction into IR
//   ddu_regs_update_wbbr        load ddu_wbbr_data into WBBR
//   ddu_regs_update_csr         update debug CSR for injection
//   ddu_wbbr_data               current address, zero-extended
//   ddu_ddata, ddu_ddata_vld    captured read data and its valid flag
//   ddu_underrun                sticky DDATA-read-without-data flag
`default_nettype none

module ct_had_ddu_ctrl #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned ADDR_STEP  = 4
) (
  input  logic        cpuclk,
  input  logic        cpurst,
  input  logic        regs_xx_ddu_en,
  input  logic        x_sm_xx_update_dr_en,
  input  logic        x_sm_xx_capture_dr_en,
  input  logic        ir_xx_daddr_reg_sel,
  input  logic        ir_xx_ddata_reg_sel,
  input  logic [63:0] jtag_xx_dr_data,
  input  logic        rtu_yy_xx_retire0_normal,
  input  logic        rtu_had_wb_data_vld,
  input  logic [63:0] rtu_had_wb_data,
  output logic        ddu_ctrl_dp_addr_sel,
  output logic        ddu_ctrl_dp_ldw_sel,
  output logic        ddu_xx_update_ir,
  output logic        ddu_regs_update_wbbr,
  output logic        ddu_regs_update_csr,
  output logic [63:0] ddu_wbbr_data,
  output logic [63:0] ddu_ddata,
  output logic        ddu_ddata_vld,
  output logic        ddu_underrun
);

  localparam int unsigned DATA_WIDTH = 64;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR_WAIT = 4'd1,
    ADDR_LD   = 4'd2,
    ADDR_RET  = 4'd3,
    LDW_LD    = 4'd4,
    LDW_RET   = 4'd5,
    DATA_RDY  = 4'd6,
    ADDR_GEN  = 4'd7
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  addr_ready;
  logic                  data_read;
  logic                  addr_load;
  logic                  addr_inc;
  logic                  ddata_cap;
  logic                  vld_set;
  logic                  vld_clr;

  assign addr_ready = x_sm_xx_update_dr_en  & ir_xx_daddr_reg_sel;
  assign data_read  = x_sm_xx_capture_dr_en & ir_xx_ddata_reg_sel;

  // Upper DR bits beyond the address width are intentionally ignored.
  generate
    if (ADDR_WIDTH < DATA_WIDTH) begin : g_unused_dr
      logic unused_dr_bits;
      assign unused_dr_bits = ^jtag_xx_dr_data[DATA_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  // State register
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and Moore strobe decode; ddu_en is only honoured in
  // ADDR_WAIT and DATA_RDY so in-flight injections always complete.
  always_comb begin
    next_state           = state;
    ddu_ctrl_dp_addr_sel = 1'b0;
    ddu_ctrl_dp_ldw_sel  = 1'b0;
    ddu_xx_update_ir     = 1'b0;
    ddu_regs_update_wbbr = 1'b0;
    ddu_regs_update_csr  = 1'b0;
    addr_load            = 1'b0;
    addr_inc             = 1'b0;
    ddata_cap            = 1'b0;
    vld_set              = 1'b0;
    vld_clr              = 1'b0;
    case (state)
      IDLE: begin
        if (regs_xx_ddu_en) next_state = ADDR_WAIT;
      end
      ADDR_WAIT: begin
        if (addr_ready) begin
          addr_load  = 1'b1;
          next_state = ADDR_LD;
        end else if (!regs_xx_ddu_en) begin
          next_state = IDLE;
        end
      end
      ADDR_LD: begin
        ddu_ctrl_dp_addr_sel = 1'b1;
        ddu_xx_update_ir     = 1'b1;
        ddu_regs_update_wbbr = 1'b1;
        ddu_regs_update_csr  = 1'b1;
        next_state           = ADDR_RET;
      end
      ADDR_RET: begin
        if (rtu_yy_xx_retire0_normal) next_state = LDW_LD;
      end
      LDW_LD: begin
        ddu_ctrl_dp_ldw_sel = 1'b1;
        ddu_xx_update_ir    = 1'b1;
        ddu_regs_update_csr = 1'b1;
        next_state          = LDW_RET;
      end
      LDW_RET: begin
        ddata_cap = rtu_had_wb_data_vld;
        if (rtu_yy_xx_retire0_normal) begin
          vld_set    = 1'b1;
          next_state = DATA_RDY;
        end
      end
      DATA_RDY: begin
        // Read-out wins over re-base, re-base wins over disable.
        if (data_read) begin
          vld_clr    = 1'b1;
          next_state = ADDR_GEN;
        end else if (addr_ready) begin
          vld_clr    = 1'b1;
          addr_load  = 1'b1;
          next_state = ADDR_LD;
        end else if (!regs_xx_ddu_en) begin
          vld_clr    = 1'b1;
          next_state = IDLE;
        end
      end
      ADDR_GEN: begin
        addr_inc   = 1'b1;
        next_state = ADDR_LD;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Upload address: loaded from DADDR, stepped after each read-out (wraps).
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      addr_q <= '0;
    end else if (addr_load) begin
      addr_q <= jtag_xx_dr_data[ADDR_WIDTH-1:0];
    end else if (addr_inc) begin
      addr_q <= addr_q + ADDR_WIDTH'(ADDR_STEP);
    end
  end

  assign ddu_wbbr_data = DATA_WIDTH'(addr_q);

  // Read data capture and its valid flag.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ddu_ddata     <= '0;
      ddu_ddata_vld <= 1'b0;
    end else begin
      if (ddata_cap) ddu_ddata <= rtu_had_wb_data;
      if (vld_set) begin
        ddu_ddata_vld <= 1'b1;
      end else if (vld_clr) begin
        ddu_ddata_vld <= 1'b0;
      end
    end
  end

`ifdef HAD_DDU_UNDERRUN_EN
  // Sticky: DDATA shifted while no word is ready; cleared only when disabled.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ddu_underrun <= 1'b0;
    end else if (!regs_xx_ddu_en) begin
      ddu_underrun <= 1'b0;
    end else if (data_read && (state != DATA_RDY)) begin
      ddu_underrun <= 1'b1;
    end
  end
`else
  assign ddu_underrun = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ct_had_ddu_ctrl.sv
// Directed self-checking bench for ct_had_ddu_ctrl.
module tb_ct_had_ddu_ctrl;

`ifdef HAD_DDU_UNDERRUN_EN
  localparam logic UR_EN = 1'b1;
`else
  localparam logic UR_EN = 1'b0;
`endif

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_ADDR = 5'b10111; // addr_sel,ldw_sel,ir,wbbr,csr
  localparam logic [4:0] S_LDW  = 5'b01101;

  logic        cpuclk = 1'b0;
  logic        cpurst;
  logic        ddu_en;
  logic        update_dr;
  logic        capture_dr;
  logic        daddr_sel;
  logic        ddata_sel;
  logic [63:0] dr_data;
  logic        retire;
  logic        wb_vld;
  logic [63:0] wb_data;
  logic        addr_sel;
  logic        ldw_sel;
  logic        update_ir;
  logic        update_wbbr;
  logic        update_csr;
  logic [63:0] wbbr_data;
  logic [63:0] ddata;
  logic        ddata_vld;
  logic        underrun;
  logic [4:0]  strb;

  int checks = 0;
  int errors = 0;

  assign strb = {addr_sel, ldw_sel, update_ir, update_wbbr, update_csr};

  always #5 cpuclk = ~cpuclk;

  ct_had_ddu_ctrl #(.ADDR_WIDTH(40), .ADDR_STEP(4)) dut (
    .cpuclk                   (cpuclk),
    .cpurst                   (cpurst),
    .regs_xx_ddu_en           (ddu_en),
    .x_sm_xx_update_dr_en     (update_dr),
    .x_sm_xx_capture_dr_en    (capture_dr),
    .ir_xx_daddr_reg_sel      (daddr_sel),
    .ir_xx_ddata_reg_sel      (ddata_sel),
    .jtag_xx_dr_data          (dr_data),
    .rtu_yy_xx_retire0_normal (retire),
    .rtu_had_wb_data_vld      (wb_vld),
    .rtu_had_wb_data          (wb_data),
    .ddu_ctrl_dp_addr_sel     (addr_sel),
    .ddu_ctrl_dp_ldw_sel      (ldw_sel),
    .ddu_xx_update_ir         (update_ir),
    .ddu_regs_update_wbbr     (update_wbbr),
    .ddu_regs_update_csr      (update_csr),
    .ddu_wbbr_data            (wbbr_data),
    .ddu_ddata                (ddata),
    .ddu_ddata_vld            (ddata_vld),
    .ddu_underrun             (underrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge cpuclk);
    #1;
  endtask

  // Called in the ADDR_LD cycle; ends in DATA_RDY holding d.
  task automatic run_word(input logic [63:0] d);
    tick();
    chk("ret_strb", 64'(strb), 64'(S_NONE));
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("ldw_strb", 64'(strb), 64'(S_LDW));
    tick();
    chk("ldwret_strb", 64'(strb), 64'(S_NONE));
    wb_vld  = 1'b1;
    wb_data = d;
    retire  = 1'b1;
    tick();
    wb_vld  = 1'b0;
    wb_data = 64'hDEAD_DEAD_DEAD_DEAD;
    retire  = 1'b0;
    chk("rdy_ddata", ddata, d);
    chk("rdy_vld", 64'(ddata_vld), 64'd1);
  endtask

  task automatic daddr_write(input logic [63:0] a);
    update_dr = 1'b1;
    daddr_sel = 1'b1;
    dr_data   = a;
  endtask

  task automatic drop_strobes();
    update_dr  = 1'b0;
    capture_dr = 1'b0;
    daddr_sel  = 1'b0;
    ddata_sel  = 1'b0;
  endtask

  initial begin
    cpurst = 1'b1; ddu_en = 1'b0; update_dr = 1'b0; capture_dr = 1'b0;
    daddr_sel = 1'b0; ddata_sel = 1'b0; dr_data = '0; retire = 1'b0;
    wb_vld = 1'b0; wb_data = '0;
    tick(); tick();
    chk("rst_strb", 64'(strb), 64'(S_NONE));
    chk("rst_wbbr", wbbr_data, 64'h0);
    chk("rst_ddata", ddata, 64'h0);
    chk("rst_vld", 64'(ddata_vld), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    cpurst = 1'b0;

    // Single word at 0x80, then auto-increment to 0x84.
    ddu_en = 1'b1;
    tick();
    chk("wait_strb", 64'(strb), 64'(S_NONE));
    daddr_write(64'h80);
    tick();
    drop_strobes();
    chk("w1_addr_strb", 64'(strb), 64'(S_ADDR));
    chk("w1_wbbr", wbbr_data, 64'h80);
    tick();
    chk("w1_ret_hold", 64'(strb), 64'(S_NONE)); // no retire yet: stays in ADDR_RET
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("w1_ldw_strb", 64'(strb), 64'(S_LDW));
    tick();
    wb_vld = 1'b1; wb_data = 64'h1122334455667788; retire = 1'b1;
    tick();
    wb_vld = 1'b0; wb_data = '0; retire = 1'b0;
    chk("w1_ddata", ddata, 64'h1122334455667788);
    chk("w1_vld", 64'(ddata_vld), 64'd1);
    capture_dr = 1'b1; ddata_sel = 1'b1;
    tick();
    drop_strobes();
    chk("w1_gen_vld", 64'(ddata_vld), 64'd0);
    chk("w1_gen_strb", 64'(strb), 64'(S_NONE));
    chk("w1_ok_underrun", 64'(underrun), 64'd0);
    tick();
    chk("w1_next_strb", 64'(strb), 64'(S_ADDR));
    chk("w1_next_wbbr", wbbr_data, 64'h84);
    chk("w1_ddata_hold", ddata, 64'h1122334455667788);

    // Re-base to the top of the 40-bit space (upper DR bits ignored), then wrap.
    run_word(64'hAAAA_0000_BBBB_0001);
    daddr_write(64'hABCD_00FF_FFFF_FFFC);
    tick();
    drop_strobes();
    chk("rb_top_strb", 64'(strb), 64'(S_ADDR));
    chk("rb_top_wbbr", wbbr_data, 64'h00FF_FFFF_FFFC);
    chk("rb_top_vld", 64'(ddata_vld), 64'd0);
    run_word(64'h0102_0304_0506_0708);
    capture_dr = 1'b1; ddata_sel = 1'b1;
    tick();
    drop_strobes();
    tick();
    chk("wrap_strb", 64'(strb), 64'(S_ADDR));
    chk("wrap_wbbr", wbbr_data, 64'h0);

    // Read-out and re-base together: read-out wins, address steps to 4.
    run_word(64'hCAFE_F00D_0000_0001);
    capture_dr = 1'b1; ddata_sel = 1'b1;
    daddr_write(64'h5000);
    tick();
    drop_strobes();
    chk("prio_gen_strb", 64'(strb), 64'(S_NONE));
    tick();
    chk("prio_wbbr", wbbr_data, 64'h4);

    // Re-base to 0x200 with an unread word: straight to ADDR_LD.
    run_word(64'h0BAD_0BAD_0BAD_0BAD);
    daddr_write(64'h200);
    tick();
    drop_strobes();
    chk("rb200_strb", 64'(strb), 64'(S_ADDR));
    chk("rb200_wbbr", wbbr_data, 64'h200);
    chk("rb200_vld", 64'(ddata_vld), 64'd0);

    // Disable mid-flight in LDW_RET; early writeback, late retire.
    tick();
    retire = 1'b1;
    tick();
    retire = 1'b0;
    tick();
    ddu_en = 1'b0;
    wb_vld = 1'b1; wb_data = 64'h5555_6666_7777_8888;
    tick();
    wb_vld = 1'b0; wb_data = 64'h9999_9999_9999_9999;
    chk("dis_wait_strb", 64'(strb), 64'(S_NONE));
    chk("dis_wait_vld", 64'(ddata_vld), 64'd0);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("dis_rdy_vld", 64'(ddata_vld), 64'd1);
    chk("dis_rdy_ddata", ddata, 64'h5555_6666_7777_8888);
    tick();
    chk("dis_idle_vld", 64'(ddata_vld), 64'd0);
    daddr_write(64'h300); // ignored in IDLE
    tick();
    drop_strobes();
    chk("dis_idle_strb", 64'(strb), 64'(S_NONE));
    chk("dis_idle_wbbr", wbbr_data, 64'h200);

    // Underrun: DDATA capture during ADDR_RET.
    ddu_en = 1'b1;
    tick();
    daddr_write(64'h1000);
    tick();
    drop_strobes();
    chk("ur_addr_wbbr", wbbr_data, 64'h1000);
    tick();
    capture_dr = 1'b1; ddata_sel = 1'b1;
    wb_vld = 1'b1; wb_data = 64'hFFFF_0000_FFFF_0000; // not captured outside LDW_RET
    tick();
    drop_strobes();
    wb_vld = 1'b0;
    chk("ur_set", 64'(underrun), 64'(UR_EN));
    chk("ur_ddata_hold", ddata, 64'h5555_6666_7777_8888);
    chk("ur_ret_strb", 64'(strb), 64'(S_NONE));
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("ur_ldw_strb", 64'(strb), 64'(S_LDW));
    tick();
    wb_vld = 1'b1; wb_data = 64'h1234; retire = 1'b1;
    tick();
    wb_vld = 1'b0; retire = 1'b0;
    chk("ur_held", 64'(underrun), 64'(UR_EN));
    ddu_en = 1'b0;
    tick();
    chk("ur_cleared", 64'(underrun), 64'd0);
    chk("ur_idle_vld", 64'(ddata_vld), 64'd0);

    // Reset during LDW_LD.
    ddu_en = 1'b1;
    tick();
    daddr_write(64'h40);
    tick();
    drop_strobes();
    tick();
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("rst2_ldw_strb", 64'(strb), 64'(S_LDW));
    cpurst = 1'b1;
    #1;
    chk("rst2_strb", 64'(strb), 64'(S_NONE));
    chk("rst2_wbbr", wbbr_data, 64'h0);
    chk("rst2_ddata", ddata, 64'h0);
    chk("rst2_vld", 64'(ddata_vld), 64'd0);
    tick();
    cpurst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1; wb_vld = 1'b1;
      tick();
      chk("rst2_quiet", 64'(strb), 64'(S_NONE));
    end
    retire = 1'b0; wb_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
